hazard_scoreboard_controller: RTL and testbench
===============================================

// Module: hazard_scoreboard_controller
// PURPOSE
//  Stall/flush controller for the ARM 5-stage pipeline, sitting beside the decode stage.
//  Tracks in-flight register and status-flag writes with per-resource pending counters.
//  Drives the decode-stage hazard input and the IF/ID flush.
//  Also provides a drain mode that stops issue until the pipeline holds no pending writes.
// PARAMETERS
//  REG_COUNT     16  architectural registers tracked (r0..r15)
//  MAX_INFLIGHT  3   max outstanding writes per resource (EX, MEM, WB stages)
//  CNT_W         2   pending-counter width; must hold MAX_INFLIGHT
//  WB_BYPASS     1   1: a same-cycle retiring writeback clears a hazard (write-through regfile)
//  PERF_W        16  stall performance-counter width
// PORTS
//  clk             in   1       pipeline clock, rising edge
//  rst             in   1       asynchronous reset, active-high
//  id_valid        in   1       decode stage holds a real instruction
//  id_src1         in   4       first source register (rn)
//  id_src2         in   4       second source (rm, or rd for stores)
//  id_two_src      in   1       id_src2 is read
//  id_src1_used    in   1       id_src1 is read (0 for MOV/MVN/branch)
//  id_wb_en        in   1       instruction writes id_dest
//  id_dest         in   4       destination register
//  id_s            in   1       instruction updates status flags
//  id_cond_used    in   1       condition field is not AL (reads status)
//  status_done     in   1       EX committed a status-register write this cycle
//  wb_en           in   1       writeback stage writes the register file
//  wb_dest         in   4       writeback destination
//  branch_taken    in   1       EX resolved a taken branch
//  drain_req       in   1       level request: stop issue and empty the scoreboard
//  hazard          out  1       stall IF and ID; decode inserts a bubble
//  flush           out  1       kill IF/ID contents
//  drain_done      out  1       DRAIN complete, scoreboard empty
//  stall_count     out  PERF_W  saturating count of cycles with hazard=1
// BEHAVIOUR
//  - Reset: all counters, outputs and stall_count = 0; state = RUN.
//  - Issue: id_valid & ~hazard & ~flush & state==RUN.
//    - Issue & id_wb_en increments cnt[id_dest].
//    - Issue & id_s increments cnt_status.
//  - Retire: wb_en decrements cnt[wb_dest]; status_done decrements cnt_status.
//  - Issue and retire on the same resource in one cycle: no net change.
//  - Decrement at 0: no change and an assertion fires. Counters never exceed MAX_INFLIGHT.
//  - The hazard term for a resource is pending(r) = cnt[r] != 0.
//    - With WB_BYPASS=1, pending(r) excludes the case cnt[r]==1 & wb_en & wb_dest==r.
//  - hazard = id_valid & ~flush & (
//      (id_src1_used & pending(id_src1)) | (id_two_src & pending(id_src2)) |
//      (id_cond_used & cnt_status!=0) | (id_wb_en & cnt[id_dest]==MAX_INFLIGHT) ).
//    - hazard is combinational from the registered counters and current inputs.
//  - flush = branch_taken, same cycle. While flush=1:
//    - The ID instruction is not counted as issued.
//    - hazard is forced to 0 so the flush wins over the stall.
//  - FSM:
//    - RUN -> DRAIN on drain_req.
//    - DRAIN: hazard=1 whenever id_valid, and no issue.
//    - DRAIN -> IDLE when all counters are 0 (checked after this cycle's retires).
//    - IDLE: drain_done=1 (registered) and hazard=1 whenever id_valid.
//    - DRAIN or IDLE -> RUN when drain_req drops; drain_done clears the same cycle.
//    - If drain_req drops in DRAIN, return to RUN with no drain_done pulse.
//  - stall_count increments on each hazard=1 cycle and saturates at all-ones.
//  - Reset mid-operation: all counters are cleared asynchronously.
//    - The pipeline registers are reset by the same rst, so no stale pending write survives.
// STRUCTURE
//  - Package arm_hazard_pkg holds REG_COUNT, MAX_INFLIGHT, CNT_W and the state encoding
//    (RUN=2'd0, DRAIN=2'd1, IDLE=2'd2).
//  - Sub-module pending_counter: CNT_W up/down counter with inc and dec inputs, inc&dec = hold,
//    an underflow flag, and outputs nonzero and full.
//    - Instantiated REG_COUNT+1 times (one per register plus one for status).
//  - Top level holds the decode compare logic, the FSM and the performance counter.
// TESTING
//  1. Write r3 (id_wb_en, id_dest=3) issued, then the next instruction reads id_src1=3
//     -> hazard=1 for 2 cycles. With wb_en=1, wb_dest=3 and WB_BYPASS=1,
//     hazard=0 in the writeback cycle and cnt[3] returns to 0.
//  2. Same-cycle issue of r5 write with wb_en=1, wb_dest=5 while cnt[5]=1 -> cnt[5] stays 1.
//     Three back-to-back r5 writes -> 4th write stalls (cnt=MAX_INFLIGHT) until one retires.
//  3. S-bit ADD issued, then a conditional (id_cond_used=1) instruction
//     -> hazard=1 until status_done=1. An AL instruction in the same slot -> no stall.
//  4. branch_taken=1 while ID holds a stalled r7 reader -> flush=1, hazard=0,
//     no counter change that cycle.
//  5. drain_req=1 with 2 writes in flight -> hazard=1 on valid ID, drain_done=1 the cycle
//     after the last wb_en. drain_req=0 -> RUN and drain_done=0.
//  6. Assert rst mid-DRAIN with counters nonzero -> all counters, outputs and stall_count
//     immediately 0. Force hazard for 2^PERF_W+5 cycles -> stall_count holds 16'hFFFF.

Source files
------------

// File: rtl/arm_hazard_pkg.sv
// ---------------------------------------------------------------------------
// arm_hazard_pkg
// Shared constants and the controller state encoding for the ARM 5-stage
// pipeline hazard scoreboard.
//   REG_COUNT     architectural registers tracked (r0..r15)
//   REG_IDX_W     width of a register specifier
//   STATUS_IDX    scoreboard slot used for the status flags (after the regs)
//   MAX_INFLIGHT  outstanding writes per resource (EX, MEM, WB)
//   CNT_W         pending-counter width, wide enough for MAX_INFLIGHT
//   ctrl_state_e  RUN / DRAIN / IDLE issue-control states
// ---------------------------------------------------------------------------
package arm_hazard_pkg;

    localparam int REG_COUNT    = 16;
    localparam int REG_IDX_W    = $clog2(REG_COUNT);
    localparam int STATUS_IDX   = REG_COUNT;
    localparam int MAX_INFLIGHT = 3;
    localparam int CNT_W        = 2;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        DRAIN = 2'd1,
        IDLE  = 2'd2
    } ctrl_state_e;

endpackage

// File: rtl/pending_counter.sv
// ---------------------------------------------------------------------------
// pending_counter
// Up/down counter of writes still in flight for one scoreboard resource.
// An increment and a decrement in the same cycle cancel out. Counting up
// stops at LIMIT and counting down stops at zero.
//   clk_i        pipeline clock, rising edge
//   rst_i        asynchronous reset, active-high
//   inc_i        a write to this resource issued this cycle
//   dec_i        a write to this resource retired this cycle
//   count_o      current number of pending writes
//   nonzero_o    at least one write pending
//   full_o       LIMIT writes pending, no room for another
//   underflow_o  a retire arrived while nothing was pending
// ---------------------------------------------------------------------------
module pending_counter
    import arm_hazard_pkg::*;
#(
    parameter int WIDTH = CNT_W,
    parameter int LIMIT = MAX_INFLIGHT
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             inc_i,
    input  logic             dec_i,
    output logic [WIDTH-1:0] count_o,
    output logic             nonzero_o,
    output logic             full_o,
    output logic             underflow_o
);

    localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Next count: a lone increment or decrement moves the count by one,
    // clamped at both ends. A decrement with nothing pending is flagged
    // so the parent can catch retires that were never issued.
    always_comb begin
        count_d     = count_q;
        underflow_o = 1'b0;
        if (inc_i && !dec_i) begin
            if (count_q != LIMIT_V) begin
                count_d = count_q + WIDTH'(1);
            end
        end else if (dec_i && !inc_i) begin
            if (count_q == '0) begin
                underflow_o = 1'b1;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // Count register, cleared by the same reset as the pipeline registers
    // so no stale pending write survives a reset.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = (count_q != '0);
    assign full_o    = (count_q == LIMIT_V);

endmodule

// File: rtl/hazard_scoreboard_controller.sv
// ---------------------------------------------------------------------------
// hazard_scoreboard_controller
// Stall/flush controller beside the decode stage of the ARM 5-stage pipeline.
// Keeps one pending-write counter per register plus one for the status
// flags, stalls decode on read-after-write, flag and capacity hazards,
// flushes IF/ID on a taken branch, and can drain the pipeline on request.
//   clk, rst                        clock and asynchronous active-high reset
//   id_valid                        decode holds a real instruction
//   id_src1/id_src1_used            first source and whether it is read
//   id_src2/id_two_src              second source and whether it is read
//   id_wb_en/id_dest                instruction writes id_dest
//   id_s                            instruction updates status flags
//   id_cond_used                    instruction reads the status flags
//   status_done                     EX committed a status write
//   wb_en/wb_dest                   writeback retires a register write
//   branch_taken                    EX resolved a taken branch
//   drain_req                       level request to stop issue and drain
//   hazard                          stall IF/ID, decode inserts a bubble
//   flush                           kill IF/ID contents
//   drain_done                      drain finished, scoreboard empty
//   stall_count                     saturating count of stalled cycles
// ---------------------------------------------------------------------------
module hazard_scoreboard_controller
    import arm_hazard_pkg::*;
#(
    parameter int WB_BYPASS = 1,
    parameter int PERF_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 id_valid,
    input  logic [REG_IDX_W-1:0] id_src1,
    input  logic [REG_IDX_W-1:0] id_src2,
    input  logic                 id_two_src,
    input  logic                 id_src1_used,
    input  logic                 id_wb_en,
    input  logic [REG_IDX_W-1:0] id_dest,
    input  logic                 id_s,
    input  logic                 id_cond_used,
    input  logic                 status_done,
    input  logic                 wb_en,
    input  logic [REG_IDX_W-1:0] wb_dest,
    input  logic                 branch_taken,
    input  logic                 drain_req,
    output logic                 hazard,
    output logic                 flush,
    output logic                 drain_done,
    output logic [PERF_W-1:0]    stall_count
);

    localparam int SLOTS = REG_COUNT + 1;

    ctrl_state_e state_q;
    ctrl_state_e state_d;

    logic [PERF_W-1:0] stallCount_q;
    logic [PERF_W-1:0] stallCount_d;

    logic [SLOTS-1:0]     cntInc;
    logic [SLOTS-1:0]     cntDec;
    logic [SLOTS-1:0]     cntNonzero;
    logic [SLOTS-1:0]     cntFull;
    logic [SLOTS-1:0]     cntUnderflow;
    logic [SLOTS-1:0]     cntZeroNext;
    logic [CNT_W-1:0]     cntValue [SLOTS];

    logic [REG_COUNT-1:0] regPending;
    logic [REG_COUNT-1:0] regFull;
    logic                 hazardTerms;
    logic                 issue;
    logic                 allClearNext;

    // One counter per architectural register, the last slot tracks the
    // status flags.
    for (genvar g = 0; g < SLOTS; g++) begin : gen_cnt
        pending_counter #(
            .WIDTH (CNT_W),
            .LIMIT (MAX_INFLIGHT)
        ) u_cnt (
            .clk_i       (clk),
            .rst_i       (rst),
            .inc_i       (cntInc[g]),
            .dec_i       (cntDec[g]),
            .count_o     (cntValue[g]),
            .nonzero_o   (cntNonzero[g]),
            .full_o      (cntFull[g]),
            .underflow_o (cntUnderflow[g])
        );
    end

    // A register is pending while its counter is nonzero. With the
    // write-through register file, the very last outstanding write retiring
    // right now is already visible to decode, so it no longer blocks.
    always_comb begin
        regPending = cntNonzero[REG_COUNT-1:0];
        for (int r = 0; r < REG_COUNT; r++) begin
            if ((WB_BYPASS != 0) && wb_en && (wb_dest == REG_IDX_W'(r)) &&
                (cntValue[r] == CNT_W'(1))) begin
                regPending[r] = 1'b0;
            end
        end
    end

    assign regFull = cntFull[REG_COUNT-1:0];

    // Decode-side hazard: read-after-write on either source, a conditional
    // instruction waiting for flags, or a destination already at its
    // in-flight limit. Outside RUN every valid instruction is held. A taken
    // branch flushes the slot, so it overrides any stall.
    always_comb begin
        hazardTerms = (id_src1_used && regPending[id_src1]) ||
                      (id_two_src   && regPending[id_src2]) ||
                      (id_cond_used && cntNonzero[STATUS_IDX]) ||
                      (id_wb_en     && regFull[id_dest]);
        flush  = branch_taken;
        hazard = id_valid && !flush && ((state_q != RUN) || hazardTerms);
    end

    assign issue = id_valid && !hazard && !flush && (state_q == RUN);

    // Scoreboard updates: issued writes count up, retiring writes count
    // down. The status slot follows S-bit issues and EX status commits.
    always_comb begin
        cntInc = '0;
        cntDec = '0;
        for (int r = 0; r < REG_COUNT; r++) begin
            cntInc[r] = issue && id_wb_en && (id_dest == REG_IDX_W'(r));
            cntDec[r] = wb_en && (wb_dest == REG_IDX_W'(r));
        end
        cntInc[STATUS_IDX] = issue && id_s;
        cntDec[STATUS_IDX] = status_done;
    end

    // The drain may finish in the same cycle as the last retire, so look
    // at what every counter will hold after this edge rather than now.
    always_comb begin
        cntZeroNext = '0;
        for (int s = 0; s < SLOTS; s++) begin
            cntZeroNext[s] = !(cntInc[s] && !cntDec[s]) &&
                             ((cntValue[s] == '0) ||
                              ((cntValue[s] == CNT_W'(1)) && cntDec[s] && !cntInc[s]));
        end
        allClearNext = &cntZeroNext;
    end

    // Issue-control state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Issue-control next state. Dropping the request always returns to
    // RUN, even mid-drain, and drain_done follows the request level so it
    // clears in the same cycle the request goes away.
    always_comb begin
        state_d    = state_q;
        drain_done = 1'b0;
        unique case (state_q)
            RUN: begin
                if (drain_req) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (!drain_req) begin
                    state_d = RUN;
                end else if (allClearNext) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                drain_done = drain_req;
                if (!drain_req) begin
                    state_d = RUN;
                end
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    // Stall performance counter, holding at all-ones once saturated.
    always_comb begin
        stallCount_d = stallCount_q;
        if (hazard && (stallCount_q != '1)) begin
            stallCount_d = stallCount_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCount_q <= '0;
        end else begin
            stallCount_q <= stallCount_d;
        end
    end

    assign stall_count = stallCount_q;

    // A retire with nothing pending means the pipeline and scoreboard
    // disagree; the flag status counter should also never be pushed past
    // its limit by back-to-back S-bit instructions.
    noUnderflow: assert property (@(posedge clk) disable iff (rst)
        cntUnderflow == '0);
    noStatusOverflow: assert property (@(posedge clk) disable iff (rst)
        !(cntInc[STATUS_IDX] && !cntDec[STATUS_IDX] && cntFull[STATUS_IDX]));

endmodule

// File: tb/tb_hazard_scoreboard_controller.sv
// ---------------------------------------------------------------------------
// tb_hazard_scoreboard_controller
// Directed bench for hazard_scoreboard_controller. Each stimulus cycle
// queues its hand-computed hazard/flush/drain_done values; a monitor on the
// falling edge pops them and compares against the DUT. The expected stall
// count is a running saturating tally of the expected hazard cycles.
// ---------------------------------------------------------------------------
module tb_hazard_scoreboard_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_two_src;
    logic        id_src1_used;
    logic        id_wb_en;
    logic [3:0]  id_dest;
    logic        id_s;
    logic        id_cond_used;
    logic        status_done;
    logic        wb_en;
    logic [3:0]  wb_dest;
    logic        branch_taken;
    logic        drain_req;
    logic        hazard;
    logic        flush;
    logic        drain_done;
    logic [15:0] stall_count;

    typedef struct {
        string       name;
        logic        hz;
        logic        fl;
        logic        dd;
        logic [15:0] sc;
    } expect_t;

    expect_t     expQ[$];
    int          compared   = 0;
    int          mismatched = 0;
    logic [15:0] expStall   = 16'd0;

    always #5 clk = ~clk;

    hazard_scoreboard_controller dut (
        .clk          (clk),
        .rst          (rst),
        .id_valid     (id_valid),
        .id_src1      (id_src1),
        .id_src2      (id_src2),
        .id_two_src   (id_two_src),
        .id_src1_used (id_src1_used),
        .id_wb_en     (id_wb_en),
        .id_dest      (id_dest),
        .id_s         (id_s),
        .id_cond_used (id_cond_used),
        .status_done  (status_done),
        .wb_en        (wb_en),
        .wb_dest      (wb_dest),
        .branch_taken (branch_taken),
        .drain_req    (drain_req),
        .hazard       (hazard),
        .flush        (flush),
        .drain_done   (drain_done),
        .stall_count  (stall_count)
    );

    // One field comparison against a queued expectation.
    task automatic cmpField(input string tag, input string field,
                            input logic [15:0] got, input logic [15:0] want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("[TB] FAIL %s.%s got %h expected %h", tag, field, got, want);
        end
    endtask

    task automatic checkOutput(input expect_t e);
        cmpField(e.name, "hazard",      {15'd0, hazard},     {15'd0, e.hz});
        cmpField(e.name, "flush",       {15'd0, flush},      {15'd0, e.fl});
        cmpField(e.name, "drain_done",  {15'd0, drain_done}, {15'd0, e.dd});
        cmpField(e.name, "stall_count", stall_count,         e.sc);
    endtask

    // Monitor: mid-cycle, away from the rising edge.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            checkOutput(expQ.pop_front());
        end
    end

    // Queue the expectation for the cycle just driven, advance the stall
    // tally, then move to just after the next rising edge.
    task automatic applyStimulus(input string name, input logic hz, input logic fl,
                                 input logic dd, input bit chk);
        expect_t e;
        if (chk) begin
            e.name = name;
            e.hz   = hz;
            e.fl   = fl;
            e.dd   = dd;
            e.sc   = expStall;
            expQ.push_back(e);
        end
        if (hz && (expStall != 16'hFFFF)) begin
            expStall = expStall + 16'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        id_valid     = 1'b0;
        id_src1      = 4'd0;
        id_src2      = 4'd0;
        id_two_src   = 1'b0;
        id_src1_used = 1'b0;
        id_wb_en     = 1'b0;
        id_dest      = 4'd0;
        id_s         = 1'b0;
        id_cond_used = 1'b0;
        status_done  = 1'b0;
        wb_en        = 1'b0;
        wb_dest      = 4'd0;
        branch_taken = 1'b0;
    endtask

    task automatic setWrite(input logic [3:0] d);
        idle();
        id_valid = 1'b1;
        id_wb_en = 1'b1;
        id_dest  = d;
    endtask

    task automatic setRead(input logic [3:0] s);
        idle();
        id_valid     = 1'b1;
        id_src1_used = 1'b1;
        id_src1      = s;
    endtask

    task automatic setRetire(input logic [3:0] d);
        wb_en   = 1'b1;
        wb_dest = d;
    endtask

    initial begin
        rst       = 1'b1;
        drain_req = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        applyStimulus("reset", 1'b0, 1'b0, 1'b0, 1'b1);
        rst = 1'b0;

        // Read-after-write on r3, released by the retiring writeback.
        setWrite(4'd3);                applyStimulus("t1_issue_w3",     0, 0, 0, 1);
        setRead(4'd3);                 applyStimulus("t1_raw_a",        1, 0, 0, 1);
        setRead(4'd3);                 applyStimulus("t1_raw_b",        1, 0, 0, 1);
        setRead(4'd3); setRetire(4'd3); applyStimulus("t1_wb_bypass",   0, 0, 0, 1);
        idle(); id_valid = 1'b1; id_two_src = 1'b1; id_src2 = 4'd3;
        applyStimulus("t1_cleared", 0, 0, 0, 1);

        // r5: issue+retire cancel, then the in-flight limit.
        setWrite(4'd5);                applyStimulus("t2_w5",           0, 0, 0, 1);
        setWrite(4'd5); setRetire(4'd5); applyStimulus("t2_inc_dec",    0, 0, 0, 1);
        setRead(4'd5);                 applyStimulus("t2_still_pend",   1, 0, 0, 1);
        setRead(4'd5); setRetire(4'd5); applyStimulus("t2_count_one",   0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            setWrite(4'd5);            applyStimulus("t2_fill",         0, 0, 0, 1);
        end
        setWrite(4'd5);                applyStimulus("t2_full_a",       1, 0, 0, 1);
        setWrite(4'd5);                applyStimulus("t2_full_b",       1, 0, 0, 1);
        setWrite(4'd5); setRetire(4'd5); applyStimulus("t2_full_wb",    1, 0, 0, 1);
        setWrite(4'd5);                applyStimulus("t2_after_wb",     0, 0, 0, 1);
        for (int k = 0; k < 3; k++) begin
            idle(); setRetire(4'd5);   applyStimulus("t2_retire",       0, 0, 0, 1);
        end
        setRead(4'd5);                 applyStimulus("t2_empty",        0, 0, 0, 1);

        // Status flags: conditional waits for the S-bit producer.
        idle(); id_valid = 1'b1; id_s = 1'b1;         applyStimulus("t3_adds",    0, 0, 0, 1);
        idle(); id_valid = 1'b1; id_cond_used = 1'b1; applyStimulus("t3_cond_a",  1, 0, 0, 1);
        idle(); id_valid = 1'b1; id_cond_used = 1'b1; applyStimulus("t3_cond_b",  1, 0, 0, 1);
        idle(); id_valid = 1'b1; id_cond_used = 1'b1; status_done = 1'b1;
        applyStimulus("t3_cond_done", 1, 0, 0, 1);
        idle(); id_valid = 1'b1; id_cond_used = 1'b1; applyStimulus("t3_cond_go", 0, 0, 0, 1);
        idle(); id_valid = 1'b1; id_s = 1'b1;         applyStimulus("t3_adds2",   0, 0, 0, 1);
        idle(); id_valid = 1'b1;                      applyStimulus("t3_al",      0, 0, 0, 1);
        idle(); status_done = 1'b1;                   applyStimulus("t3_retire",  0, 0, 0, 1);
        idle(); id_valid = 1'b1; id_cond_used = 1'b1; applyStimulus("t3_clear",   0, 0, 0, 1);

        // Taken branch beats a stall and suppresses issue.
        setWrite(4'd7);                applyStimulus("t4_w7",           0, 0, 0, 1);
        setRead(4'd7);                 applyStimulus("t4_stall",        1, 0, 0, 1);
        setRead(4'd7); branch_taken = 1'b1; applyStimulus("t4_flush_rd", 0, 1, 0, 1);
        setRead(4'd7);                 applyStimulus("t4_stall_again",  1, 0, 0, 1);
        setWrite(4'd7); branch_taken = 1'b1; applyStimulus("t4_flush_wr", 0, 1, 0, 1);
        idle(); setRetire(4'd7);       applyStimulus("t4_retire",       0, 0, 0, 1);
        setRead(4'd7);                 applyStimulus("t4_clear",        0, 0, 0, 1);

        // Drain with two writes in flight.
        setWrite(4'd2);                applyStimulus("t5_w2",           0, 0, 0, 1);
        setWrite(4'd4);                applyStimulus("t5_w4",           0, 0, 0, 1);
        idle(); drain_req = 1'b1;      applyStimulus("t5_enter",        0, 0, 0, 1);
        setRead(4'd0);                 applyStimulus("t5_drain_stall",  1, 0, 0, 1);
        setRead(4'd0); setRetire(4'd2); applyStimulus("t5_drain_wb2",   1, 0, 0, 1);
        setRead(4'd0); setRetire(4'd4); applyStimulus("t5_drain_wb4",   1, 0, 0, 1);
        setRead(4'd0);                 applyStimulus("t5_done_valid",   1, 0, 1, 1);
        idle();                        applyStimulus("t5_done_idle",    0, 0, 1, 1);
        drain_req = 1'b0;              applyStimulus("t5_release",      0, 0, 0, 1);
        setRead(4'd0);                 applyStimulus("t5_run",          0, 0, 0, 1);

        // Drain abandoned before it completes.
        setWrite(4'd6);                applyStimulus("t5b_w6",          0, 0, 0, 1);
        idle(); drain_req = 1'b1;      applyStimulus("t5b_enter",       0, 0, 0, 1);
        drain_req = 1'b0;              applyStimulus("t5b_abort",       0, 0, 0, 1);
        idle(); setRetire(4'd6);       applyStimulus("t5b_retire",      0, 0, 0, 1);
        setRead(4'd0);                 applyStimulus("t5b_run",         0, 0, 0, 1);

        // Asynchronous reset in the middle of a drain.
        setWrite(4'd1);                applyStimulus("t6_w1",           0, 0, 0, 1);
        setWrite(4'd8);                applyStimulus("t6_w8",           0, 0, 0, 1);
        idle(); drain_req = 1'b1;      applyStimulus("t6_enter",        0, 0, 0, 1);
        setRead(4'd1);                 applyStimulus("t6_drain",        1, 0, 0, 1);
        setRead(4'd1); drain_req = 1'b0; rst = 1'b1; expStall = 16'd0;
        applyStimulus("t6_async_rst", 0, 0, 0, 1);
        rst = 1'b0;
        setRead(4'd1);                 applyStimulus("t6_r1_clear",     0, 0, 0, 1);
        setRead(4'd8);                 applyStimulus("t6_r8_clear",     0, 0, 0, 1);

        // Long forced stall to saturate the performance counter.
        setRead(4'd0); drain_req = 1'b1; applyStimulus("t6_sat_enter",  0, 0, 0, 1);
        for (int i = 0; i < 65541; i++) begin
            applyStimulus("t6_sat", 1'b1, 1'b0, (i > 0),
                          (i < 2) || ((i >= 65533) && (i <= 65537)) || (i == 65540));
        end
        idle(); drain_req = 1'b0;      applyStimulus("t6_sat_hold",     0, 0, 0, 1);

        @(negedge clk);
        #1;
        if (expQ.size() != 0) begin
            mismatched++;
            $display("[TB] FAIL queue_drain got %0d pending expected 0", expQ.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
